seq_mult: RTL

- Parametrised sequential shift-add multiplier.
- Successor to the fixed 4x4 combinational multiplier path built on the 4-bit ripple-carry adder: generalised to WIDTH-bit operands with a 2*WIDTH-bit product.
- Adds signed/unsigned mode and a start/busy/done handshake.
- One partial-product addition per clock, so area is one WIDTH+1-bit adder, not a full array.

---
 rtl/seq_mult_pkg.sv | 18 +
 rtl/rca_nbit.sv | 26 ++
 rtl/seq_mult.sv | 108 ++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Bits needed to count 0 .. v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder. The carry out of the top bit is dropped, so the
// caller sizes N one bit wider than the operands it adds.
module rca_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum
);

  logic [N-1:0] w_c;

  assign w_c[0] = i_cin;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_fa
      assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      if (gi < N - 1) begin : g_c
        assign w_c[gi+1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial-product add per clock,
// signed/unsigned operands handled as sign-magnitude around an unsigned core.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);

  state_t             r_state, w_next;
  logic [2*WIDTH-1:0] r_acc, r_p;
  logic [WIDTH-1:0]   r_mcand, r_mplr;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;

  logic [WIDTH-1:0]   w_xmag, w_ymag;
  logic [WIDTH:0]     w_add_a, w_add_b, w_sum;
  logic [2*WIDTH-1:0] w_acc_neg;
  logic               w_last;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
  assign w_xmag = (signed_mode & X[WIDTH-1]) ? (~X + ONE_W) : X;
  assign w_ymag = (signed_mode & Y[WIDTH-1]) ? (~Y + ONE_W) : Y;

  // Upper half of the accumulator plus the multiplicand, gated by multiplier LSB.
  assign w_add_a   = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_add_b   = r_mplr[0] ? {1'b0, r_mcand} : '0;
  assign w_acc_neg = ~r_acc + ONE_2W;
  assign w_last    = (r_cnt == LAST);
  assign P         = r_p;

  rca_nbit #(.N(WIDTH + 1)) u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_FIN;
      end
      S_FIN: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands, shift-add, then sign-correct into P.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_p     <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mcand <= w_xmag;
          r_mplr  <= w_ymag;
          r_neg   <= signed_mode & (X[WIDTH-1] ^ Y[WIDTH-1]);
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_acc  <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + CW'(1);
        end
        S_FIN:   r_p <= r_neg ? w_acc_neg : r_acc;
        default: ;
      endcase
    end
  end

endmodule
